// File: rtl/fifo_drain_sum_pkg.sv
// fifo_drain_sum_pkg
//   Shared definitions for the FIFO drain-and-sum block.
//   - state_t    : controller state encoding (IDLE, DRAIN, EMIT)
//   - DATA_W_DEF : default data/sum width
//   - CNT_W_DEF  : default word-count width
package fifo_drain_sum_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_drain_sum.sv
// fifo_drain_sum
//   Accepts a job of N words, dequeues N words from an upstream FIFO,
//   accumulates them modulo 2^DATA_W, then enqueues the sum downstream.
//
//   Ports
//     CLK, RST          : clock, synchronous active-high reset
//     start__ENA/RDY    : job request / block idle
//     start_count       : number of words in the job (sampled with start)
//     src_first(__RDY)  : upstream head word and its valid flag
//     src_deq__RDY/ENA  : upstream dequeue ready / strobe
//     res_enq__RDY/ENA  : downstream enqueue ready / strobe
//     res_enq_v         : result word (the registered sum)
//     busy              : high whenever not IDLE
//     state_dbg         : current controller state, for observation only
//
//   Handshake rule for every __ENA/__RDY pair: an ENA is a combinational
//   function of its own RDY and is never high while that RDY is low; the
//   transfer happens on the rising edge of any cycle where ENA is high.
module fifo_drain_sum
    import fifo_drain_sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start__ENA,
    input  logic [CNT_W-1:0]  start_count,
    output logic              start__RDY,
    input  logic [DATA_W-1:0] src_first,
    input  logic              src_first__RDY,
    input  logic              src_deq__RDY,
    output logic              src_deq__ENA,
    input  logic              res_enq__RDY,
    output logic              res_enq__ENA,
    output logic [DATA_W-1:0] res_enq_v,
    output logic              busy,
    output state_t            state_dbg
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]  sum_q, sum_d;

    // State, counter and accumulator registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        sum_d        = sum_q;
        start__RDY   = 1'b0;
        src_deq__ENA = 1'b0;
        res_enq__ENA = 1'b0;

        unique case (state_q)
            IDLE: begin
                start__RDY = 1'b1;
                if (start__ENA) begin
                    sum_d = '0;
                    if (start_count == '0) begin
                        // Empty job: nothing to drain, emit a zero sum.
                        state_d = EMIT;
                    end else begin
                        remaining_d = start_count;
                        state_d     = DRAIN;
                    end
                end
            end

            DRAIN: begin
                src_deq__ENA = src_deq__RDY & src_first__RDY;
                if (src_deq__ENA) begin
                    // Carry out of the top bit is discarded by width.
                    sum_d       = sum_q + src_first;
                    remaining_d = remaining_q - 1'b1;
                    // remaining_q never reaches 0 inside DRAIN, so the
                    // decrement cannot wrap.
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                res_enq__ENA = res_enq__RDY;
                if (res_enq__RDY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_enq_v = sum_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_drain_sum.sv
// tb_fifo_drain_sum
//   Self-checking bench for fifo_drain_sum. A job-level reference model
//   (words-left count, accumulated sum, expected-result queue) predicts
//   every handshake strobe and the result word cycle by cycle.
module tb_fifo_drain_sum;
    import fifo_drain_sum_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start__ENA;
    logic [CW-1:0] start_count;
    logic          start__RDY;
    logic [DW-1:0] src_first;
    logic          src_first__RDY;
    logic          src_deq__RDY;
    logic          src_deq__ENA;
    logic          res_enq__RDY;
    logic          res_enq__ENA;
    logic [DW-1:0] res_enq_v;
    logic          busy;
    state_t        state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_res;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    fifo_drain_sum #(.DATA_W(DW), .CNT_W(CW)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start__ENA     (start__ENA),
        .start_count    (start_count),
        .start__RDY     (start__RDY),
        .src_first      (src_first),
        .src_first__RDY (src_first__RDY),
        .src_deq__RDY   (src_deq__RDY),
        .src_deq__ENA   (src_deq__ENA),
        .res_enq__RDY   (res_enq__RDY),
        .res_enq__ENA   (res_enq__ENA),
        .res_enq_v      (res_enq_v),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller is positioned just after a rising edge. start__ENA is held
    // high across the reset edge to show reset wins.
    task automatic do_reset();
        RST            = 1'b1;
        start__ENA     = 1'b1;
        start_count    = 8'd5;
        src_first      = '0;
        src_first__RDY = 1'b1;
        src_deq__RDY   = 1'b1;
        res_enq__RDY   = 1'b1;
        @(posedge CLK); #1;
        RST        = 1'b0;
        start__ENA = 1'b0;
        src_q.delete();
        exp_q.delete();
        last_res = '0;
        @(negedge CLK);
        check("rst_start_rdy", start__RDY, 1);
        check("rst_busy", busy, 0);
        check("rst_deq_ena", src_deq__ENA, 0);
        check("rst_enq_ena", res_enq__ENA, 0);
        check("rst_res_v", res_enq_v, 0);
    endtask

    // ---------------- driver + model ----------------
    // mode 0: all RDYs high; mode 1: src_first__RDY toggles; mode 2: random.
    // emit_stall: EMIT cycles with res_enq__RDY forced low before release.
    // poke: random start__ENA/start_count while the job runs.
    // abort_at: reset once this many words are dequeued (-1 = never).
    task automatic run_job(input int n, input int mode, input int emit_stall,
                           input bit poke, input int abort_at);
        int            words_left;
        int            deq_done;
        int            stall_left;
        logic [DW-1:0] acc;
        bit            in_emit;
        bit            done;
        bit            aborted;
        bit            exp_deq;
        bit            exp_enq;

        while (src_q.size() < n) src_q.push_back($urandom);

        @(posedge CLK); #1;
        start__ENA     = 1'b1;
        start_count    = n[CW-1:0];
        src_first__RDY = 1'b0;
        src_deq__RDY   = 1'b0;
        res_enq__RDY   = 1'b0;
        @(negedge CLK);
        check("start_rdy_idle", start__RDY, 1);
        check("busy_idle", busy, 0);

        words_left = n;
        deq_done   = 0;
        acc        = '0;
        in_emit    = (n == 0);
        if (in_emit) exp_q.push_back('0);
        stall_left = emit_stall;
        done       = 0;
        aborted    = 0;

        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(posedge CLK); #1;
            if (abort_at >= 0 && deq_done == abort_at) begin
                aborted = 1;
                break;
            end
            start__ENA  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            start_count = CW'($urandom);
            src_first   = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
            case (mode)
                0: begin src_first__RDY = 1'b1; src_deq__RDY = 1'b1; end
                1: begin src_first__RDY = ((cyc % 2) == 1); src_deq__RDY = 1'b1; end
                default: begin
                    src_first__RDY = 1'($urandom_range(0, 1));
                    src_deq__RDY   = 1'($urandom_range(0, 3) != 0);
                end
            endcase
            if (in_emit && stall_left > 0) begin
                res_enq__RDY = 1'b0;
                stall_left--;
            end else begin
                res_enq__RDY = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end

            @(negedge CLK);
            check("job_start_rdy", start__RDY, 0);
            check("job_busy", busy, 1);
            exp_deq = !in_emit && words_left > 0 && src_deq__RDY && src_first__RDY;
            exp_enq = in_emit && res_enq__RDY;
            check("deq_ena", src_deq__ENA, exp_deq);
            check("enq_ena", res_enq__ENA, exp_enq);
            if (in_emit) check("res_v", res_enq_v, exp_q[0]);

            if (exp_deq) begin
                acc = acc + src_q.pop_front();
                words_left--;
                deq_done++;
                if (words_left == 0) begin
                    in_emit = 1;
                    exp_q.push_back(acc);
                end
            end else if (exp_enq) begin
                last_res = exp_q.pop_front();
                done     = 1;
            end
        end

        if (aborted) begin
            do_reset();
        end else begin
            if (!done) check("job_timeout", 0, 1);
            @(posedge CLK); #1;
            start__ENA     = 1'b0;
            src_first__RDY = 1'b1;
            src_deq__RDY   = 1'b1;
            res_enq__RDY   = 1'b1;
            @(negedge CLK);
            check("post_start_rdy", start__RDY, 1);
            check("post_busy", busy, 0);
            check("post_deq_ena", src_deq__ENA, 0);
            check("post_enq_ena", res_enq__ENA, 0);
            check("post_res_hold", res_enq_v, last_res);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST            = 1'b1;
        start__ENA     = 1'b0;
        start_count    = '0;
        src_first      = '0;
        src_first__RDY = 1'b0;
        src_deq__RDY   = 1'b0;
        res_enq__RDY   = 1'b0;
        last_res       = '0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Three words, all ready: consecutive dequeues then sum 21.
        src_q = '{32'd5, 32'd7, 32'd9};
        run_job(3, 0, 0, 0, -1);
        check("sum_5_7_9", res_enq_v, 32'd21);

        // Empty job: immediate emit of zero.
        run_job(0, 0, 0, 0, -1);
        check("sum_empty", res_enq_v, 32'd0);

        // Modular wrap.
        src_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_job(2, 0, 0, 0, -1);
        check("sum_wrap", res_enq_v, 32'h0000_0001);

        // Toggled source valid and a 5-cycle downstream stall.
        run_job(4, 1, 5, 0, -1);

        // Reset after 2 of 4 dequeues, then a fresh single-word job.
        @(posedge CLK); #1;
        run_job(4, 0, 0, 0, 2);
        src_q = '{32'd3};
        run_job(1, 0, 0, 0, -1);
        check("sum_after_abort", res_enq_v, 32'd3);

        // Start pulses during a running job are ignored.
        run_job(9, 0, 0, 1, -1);

        // Maximum count drains exactly that many words.
        run_job(255, 2, 2, 1, -1);

        // Random jobs, some aborted by reset.
        for (int j = 0; j < 40; j++) begin
            int n;
            int ab;
            n  = $urandom_range(0, 20);
            ab = -1;
            if (n > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, n);
            run_job(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
